// File: rtl/parity_serializer.sv
// rtl/parity_serializer.sv - UART-style frame serializer: start, LSB-first data, parity, stop (PARITY_SERIALIZER_STOP2_EN adds a second stop bit)
module parity_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int         IDX_W    = 5;
    localparam logic [15:0] RELOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
`ifdef PARITY_SERIALIZER_STOP2_EN
    logic                  stop_q, stop_d;
`endif
    logic                  bit_end;

    // The current bit period ends when the down-counter reaches zero
    assign bit_end = (cnt_q == 16'd0);

    // State register and datapath; reset clears everything and returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
`ifdef PARITY_SERIALIZER_STOP2_EN
            stop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
`ifdef PARITY_SERIALIZER_STOP2_EN
            stop_q  <= stop_d;
`endif
        end
    end

    // Next-state, bit timing and line outputs; parity accumulates from bits as they are shifted out
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
`ifdef PARITY_SERIALIZER_STOP2_EN
        stop_d     = stop_q;
`endif
        in_ready   = 1'b0;
        busy       = 1'b0;
        serial_out = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_START;
                    shift_d = in_data;
                    par_d   = (ODD_PARITY != 0);
                    cnt_d   = RELOAD;
                    idx_d   = '0;
                end
            end
            S_START: begin
                busy       = 1'b1;
                serial_out = 1'b0;
                cnt_d      = bit_end ? RELOAD : cnt_q - 16'd1;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                busy       = 1'b1;
                serial_out = shift_q[0];
                cnt_d      = bit_end ? RELOAD : cnt_q - 16'd1;
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                busy       = 1'b1;
                serial_out = par_q;
                cnt_d      = bit_end ? RELOAD : cnt_q - 16'd1;
                if (bit_end) begin
                    state_d = S_STOP;
`ifdef PARITY_SERIALIZER_STOP2_EN
                    stop_d  = 1'b0;
`endif
                end
            end
            S_STOP: begin
                busy       = 1'b1;
                serial_out = 1'b1;
                cnt_d      = bit_end ? RELOAD : cnt_q - 16'd1;
`ifdef PARITY_SERIALIZER_STOP2_EN
                if (bit_end) begin
                    if (!stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        stop_d     = 1'b0;
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
`else
                if (bit_end) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            in_ready   = 1'b0;
            busy       = 1'b0;
            serial_out = 1'b1;
            frame_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_serializer.sv
// tb/tb_parity_serializer.sv - self-checking bench for parity_serializer against a frame-level reference model
module tb_parity_serializer;

`ifdef PARITY_SERIALIZER_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic       clk = 1'b0;
    logic [1:0] rst_a;
    logic [1:0] vld_a;
    logic [1:0] rdy_w;
    logic [1:0] so_w;
    logic [1:0] busy_w;
    logic [1:0] done_w;
    logic [7:0] dat_a [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .ODD_PARITY(0)) u_dut0 (
        .clk(clk), .rst(rst_a[0]), .in_data(dat_a[0]), .in_valid(vld_a[0]),
        .in_ready(rdy_w[0]), .serial_out(so_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
    );

    parity_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .ODD_PARITY(1)) u_dut1 (
        .clk(clk), .rst(rst_a[1]), .in_data(dat_a[1]), .in_valid(vld_a[1]),
        .in_ready(rdy_w[1]), .serial_out(so_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cpb_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return (8 + 2 + STOP_BITS) * cpb_of(k);
    endfunction

    // Line level expected c cycles after the transfer (c = 1 is the first start-bit cycle)
    function automatic logic exp_line(input int k, input logic [7:0] w, input int c);
        int bitno;
        logic odd;
        bitno = (c - 1) / cpb_of(k);
        odd   = (k == 1);
        if (bitno == 0) return 1'b0;
        if (bitno <= 8) return w[bitno-1];
        if (bitno == 9) return (^w) ^ odd;
        return 1'b1;
    endfunction

    task automatic check_idle(input int k, input string tag);
        chk($sformatf("%s_so%0d", tag, k), so_w[k], 1);
        chk($sformatf("%s_busy%0d", tag, k), busy_w[k], 0);
        chk($sformatf("%s_rdy%0d", tag, k), rdy_w[k], 1);
        chk($sformatf("%s_done%0d", tag, k), done_w[k], 0);
    endtask

    // Called at the negedge of the first cycle after a transfer; ends at the negedge of the last frame cycle
    task automatic check_frame(input int k, input logic [7:0] w, input bit inject);
        int len;
        len = frame_len(k);
        for (int c = 1; c <= len; c++) begin
            chk($sformatf("so%0d_w%0h_c%0d", k, w, c), so_w[k], exp_line(k, w, c));
            chk($sformatf("done%0d_c%0d", k, c), done_w[k], (c == len));
            chk($sformatf("busy%0d_c%0d", k, c), busy_w[k], 1);
            chk($sformatf("rdy%0d_c%0d", k, c), rdy_w[k], 0);
            if (inject) begin
                if (c < len && $urandom_range(0, 3) == 0) begin
                    vld_a[k] = 1'b1;
                    dat_a[k] = 8'hFF;
                end else begin
                    vld_a[k] = 1'b0;
                    dat_a[k] = 8'($urandom);
                end
            end
            if (c < len) @(negedge clk);
        end
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (rdy_w[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready_wait%0d", k), rdy_w[k], 1);
    endtask

    task automatic send(input int k, input logic [7:0] w, input bit inject);
        wait_ready(k);
        vld_a[k] = 1'b1;
        dat_a[k] = w;
        @(negedge clk);
        vld_a[k] = 1'b0;
        dat_a[k] = 8'($urandom);
        check_frame(k, w, inject);
        vld_a[k] = 1'b0;
        @(negedge clk);
        check_idle(k, "post");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_a    = 2'b11;
        vld_a    = 2'b11;
        dat_a[0] = 8'hFF;
        dat_a[1] = 8'hFF;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_so%0d", k), so_w[k], 1);
            chk($sformatf("rst_rdy%0d", k), rdy_w[k], 0);
            chk($sformatf("rst_busy%0d", k), busy_w[k], 0);
            chk($sformatf("rst_done%0d", k), done_w[k], 0);
        end
        vld_a = 2'b00;
        rst_a = 2'b00;
        #1;
        check_idle(0, "rel");
        check_idle(1, "rel");

        send(0, 8'hA5, 1'b0);
        send(0, 8'h01, 1'b0);
        send(1, 8'h01, 1'b0);
        send(1, 8'h00, 1'b0);

        for (int i = 0; i < 6; i++) begin
            send(0, 8'($urandom), 1'b1);
            send(1, 8'($urandom), 1'b1);
        end

        // in_valid held high across two frames on the single-cycle-per-bit instance
        wait_ready(1);
        vld_a[1] = 1'b1;
        dat_a[1] = 8'h3C;
        @(negedge clk);
        dat_a[1] = 8'hC3;
        check_frame(1, 8'h3C, 1'b0);
        @(negedge clk);
        check_idle(1, "gap");
        @(negedge clk);
        vld_a[1] = 1'b0;
        dat_a[1] = 8'h00;
        check_frame(1, 8'hC3, 1'b0);
        @(negedge clk);
        check_idle(1, "b2b_end");

        // reset in the middle of data bit 3 aborts the frame
        wait_ready(0);
        vld_a[0] = 1'b1;
        dat_a[0] = 8'hA5;
        @(negedge clk);
        vld_a[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_bit3", so_w[0], exp_line(0, 8'hA5, 18));
        chk("pre_rst_busy", busy_w[0], 1);
        rst_a[0] = 1'b1;
        #1;
        chk("in_rst_so", so_w[0], 1);
        chk("in_rst_rdy", rdy_w[0], 0);
        chk("in_rst_busy", busy_w[0], 0);
        chk("in_rst_done", done_w[0], 0);
        @(negedge clk);
        rst_a[0] = 1'b0;
        #1;
        check_idle(0, "after_rst");
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk($sformatf("abort_so_c%0d", c), so_w[0], 1);
            chk($sformatf("abort_done_c%0d", c), done_w[0], 0);
        end

        send(0, 8'($urandom), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_serializer.md
PARITY_SERIALIZER -- requirements
Module: parity_serializer

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of payload bits per frame (legal 1..16).
REQ-002 Parameter: CLKS_PER_BIT, default 4, clock cycles each serial bit is held (legal 1..65535).
REQ-003 Parameter: ODD_PARITY, default 0; 0 selects even parity, 1 selects odd parity.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: in_data  input  DATA_WIDTH  payload word to serialize.
REQ-007 Port: in_valid  input  1  in_data is valid this cycle.
REQ-008 Port: in_ready  output  1  block can accept a word this cycle.
REQ-009 Port: serial_out  output  1  serial line; idles high.
REQ-010 Port: busy  output  1  high while a frame is being transmitted.
REQ-011 Port: frame_done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE: in_ready=1, busy=0, serial_out=1.
REQ-014 A transfer SHALL occur on the cycle where in_valid and in_ready are both 1; in_data is captured into a shift register and the FSM moves to START.
REQ-015 in_valid SHALL be ignored outside IDLE; in_ready is 0 in every state other than IDLE.
REQ-016 serial_out SHALL drive the start bit (0) starting the cycle after the transfer (latency 1).
REQ-017 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that reloads on every bit boundary.
REQ-018 DATA SHALL send DATA_WIDTH bits LSB first, counted by a bit index that wraps to 0 on exit from DATA.
REQ-019 The parity bit SHALL equal the XOR of all captured bits, inverted when ODD_PARITY=1.
REQ-020 Parity SHALL be computed from the captured word, never from live in_data.
REQ-021 STOP SHALL drive 1 for one bit period.
REQ-022 frame_done SHALL pulse high on the final cycle of the final stop bit; the FSM is in IDLE the following cycle.
REQ-023 Consecutive frames SHALL be separated by at least one IDLE cycle, with serial_out=1 during that cycle.
REQ-024 busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-025 Total frame length SHALL be (DATA_WIDTH+3)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT when the second stop bit is configured in (REQ-030).
REQ-026 With CLKS_PER_BIT=1, each state SHALL still last exactly one cycle per bit.

Reset
REQ-027 While rst=1, the block SHALL force IDLE, serial_out=1, in_ready=0, busy=0 and frame_done=0, and clear all counters and the shift register.
REQ-028 in_ready SHALL rise on the first cycle after rst deasserts.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse and no partial bits sent after reset.

Configuration
REQ-030 Macro PARITY_SERIALIZER_STOP2_EN: when defined, STOP SHALL last two bit periods, with frame_done on the last cycle of the second stop bit; when undefined, STOP lasts one bit period.

Verification
REQ-031 Defaults, send 0xA5 -> serial_out holds each bit 4 cycles: 0,1,0,1,0,0,1,0,1,0(parity),1; frame_done at cycle 44 after the transfer.
REQ-032 ODD_PARITY=1, send 0x01 -> parity bit 0; ODD_PARITY=0, send 0x01 -> parity bit 1.
REQ-033 Pulse in_valid with 0xFF while busy -> no transfer, and the current frame is unchanged.
REQ-034 rst pulsed during DATA bit 3 -> serial_out=1 on the next cycle, no frame_done, in_ready=1 once rst deasserts.
REQ-035 CLKS_PER_BIT=1, in_valid held high with 0x3C then 0xC3 -> two 11-cycle frames separated by exactly one IDLE cycle.
REQ-036 PARITY_SERIALIZER_STOP2_EN defined, send 0x00 -> stop high for 8 cycles, frame_done at cycle 48 after the transfer.
